// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame width and default bit period.
// Latency: none (package only).
// Backpressure: not applicable.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 2;

    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_START  = 3'b001;
    localparam logic [2:0] ST_DATA   = 3'b010;
    localparam logic [2:0] ST_STOP   = 3'b011;
    localparam logic [2:0] ST_PARITY = 3'b100;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Latency: bit_end is a decode of the registered count, valid in the same cycle.
// Backpressure: none; clear holds the count at zero.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic clear,
    output logic bit_end
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    logic [15:0] clk_cnt;

    assign bit_end = (clk_cnt == LAST_CNT);

    always_ff @(posedge i_Clock) begin
        if (i_Reset || clear || bit_end) begin
            clk_cnt <= '0;
        end else begin
            clk_cnt <= clk_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1/8N2 LSB first; define UART_TX_PARITY_EN to add a parity bit.
// Latency: byte accepted on edge k starts its start bit after edge k+1; frames chain with no gap.
// Backpressure: one-entry holding register; o_Tx_Ready low while full, writes then are dropped.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
        $error("uart_tx: illegal parameter combination");
    end

    localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    logic [2:0] state;
    logic [7:0] hold_dat;
    logic       hold_vld;
    logic [7:0] shift_dat;
    logic [2:0] bit_idx;
    logic       tx_serial;
    logic       bit_end;
    logic       accept;
    logic       frame_end;
    logic       load;
`ifdef UART_TX_PARITY_EN
    logic       par_bit;
`endif

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .clear   (state == ST_IDLE),
        .bit_end (bit_end)
    );

    assign accept    = i_Tx_DV && !hold_vld;
    assign frame_end = (state == ST_STOP) && bit_end && (bit_idx == LAST_STOP);
    // Drain the holding register from IDLE or straight out of the last stop cycle.
    assign load      = hold_vld && ((state == ST_IDLE) || frame_end);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state     <= ST_IDLE;
            hold_dat  <= '0;
            hold_vld  <= 1'b0;
            shift_dat <= '0;
            bit_idx   <= '0;
            tx_serial <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                hold_vld <= 1'b1;
                hold_dat <= i_Tx_Byte;
            end else if (load) begin
                hold_vld <= 1'b0;
            end

            if (load) begin
                state     <= ST_START;
                shift_dat <= hold_dat;
                bit_idx   <= '0;
                tx_serial <= 1'b0;
`ifdef UART_TX_PARITY_EN
                par_bit   <= (^hold_dat) ^ 1'(PARITY_ODD);
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        tx_serial <= 1'b1;
                    end
                    ST_START: begin
                        if (bit_end) begin
                            state     <= ST_DATA;
                            tx_serial <= shift_dat[0];
                        end
                    end
                    ST_DATA: begin
                        if (bit_end) begin
                            if (bit_idx == LAST_DATA) begin
                                bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
                                state     <= ST_PARITY;
                                tx_serial <= par_bit;
`else
                                state     <= ST_STOP;
                                tx_serial <= 1'b1;
`endif
                            end else begin
                                bit_idx   <= bit_idx + 3'd1;
                                shift_dat <= shift_dat >> 1;
                                tx_serial <= shift_dat[1];
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: begin
                        if (bit_end) begin
                            state     <= ST_STOP;
                            tx_serial <= 1'b1;
                        end
                    end
`endif
                    ST_STOP: begin
                        // bit_idx counts stop bits here
                        if (bit_end) begin
                            if (bit_idx == LAST_STOP) begin
                                state   <= ST_IDLE;
                                bit_idx <= '0;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        tx_serial <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_Tx_Ready  = !hold_vld;
    assign o_Tx_Active = (state != ST_IDLE);
    assign o_Tx_Serial = tx_serial;
    assign o_Tx_Done   = frame_end;

endmodule
